// File: rtl/mips_writeback_stage.sv
// MIPS32 writeback stage: selects ALU result or extended load data and drives the register-file write port.
// Latency 1 cycle from transfer (ALU) or from mem_rvalid (load); in_ready low while a load is outstanding.
// Optional load-response timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module mips_writeback_stage #(
    parameter int MIPS_REG_ADDR_W_m1 = 4,
    parameter int MIPS_REG_DATA_W_m1 = 31,
    parameter int TIMEOUT_CYCLES     = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_reg_write,
    input  logic                          in_mem_to_reg,
    input  logic [MIPS_REG_ADDR_W_m1:0]   in_write_addr,
    input  logic [MIPS_REG_DATA_W_m1:0]   in_alu_result,
    input  logic [1:0]                    in_load_size,
    input  logic                          in_load_signed,
    input  logic                          mem_rvalid,
    input  logic [MIPS_REG_DATA_W_m1:0]   mem_rdata,
    output logic                          RegWrite,
    output logic [MIPS_REG_ADDR_W_m1:0]   WriteAddr,
    output logic [MIPS_REG_DATA_W_m1:0]   WriteData,
    output logic                          fwd_valid,
    output logic [MIPS_REG_ADDR_W_m1:0]   fwd_addr,
    output logic                          load_error
);
    localparam int DW = MIPS_REG_DATA_W_m1 + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT_MEM} state_t;

    state_t                        state_q, state_d;
    logic [MIPS_REG_ADDR_W_m1:0]   addr_q, addr_d;
    logic [MIPS_REG_DATA_W_m1:0]   data_q, data_d;
    logic                          wr_en_q, wr_en_d;
    logic [1:0]                    size_q, size_d;
    logic                          sgn_q, sgn_d;
    logic [1:0]                    off_q, off_d;
    logic                          load_error_q, load_error_d;
    logic                          xfer;
    logic                          tmo_expire;
    logic [7:0]                    byte_v;
    logic [15:0]                   half_v;
    logic [MIPS_REG_DATA_W_m1:0]   load_val;

    assign xfer = in_valid && (state_q != S_WAIT_MEM);

    // Little-endian lane select; a halfword only looks at the upper offset bit.
    always_comb begin
        byte_v   = mem_rdata[{off_q, 3'b000} +: 8];
        half_v   = mem_rdata[{off_q[1], 4'b0000} +: 16];
        load_val = mem_rdata;
        case (size_q)
            2'b00:   load_val = {{(DW-8){sgn_q & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{(DW-16){sgn_q & half_v[15]}}, half_v};
            default: load_val = mem_rdata;
        endcase
    end

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (state_q == S_WAIT_MEM && !mem_rvalid) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end

    // A response arriving on the expiry cycle still completes the load.
    assign tmo_expire = (tmo_q == CW'(TIMEOUT_CYCLES - 1)) && !mem_rvalid;
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            wr_en_q      <= 1'b0;
            size_q       <= 2'b00;
            sgn_q        <= 1'b0;
            off_q        <= 2'b00;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wr_en_q      <= wr_en_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            off_q        <= off_d;
            load_error_q <= load_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wr_en_d      = wr_en_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        off_d        = off_q;
        load_error_d = load_error_q;
        unique case (state_q)
            S_IDLE, S_WRITE: begin
                if (xfer) begin
                    addr_d  = in_write_addr;
                    wr_en_d = in_reg_write && (in_write_addr != '0);
                    if (in_mem_to_reg) begin
                        size_d  = in_load_size;
                        sgn_d   = in_load_signed;
                        off_d   = in_alu_result[1:0];
                        state_d = S_WAIT_MEM;
                    end else begin
                        data_d  = in_alu_result;
                        state_d = S_WRITE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    data_d  = load_val;
                    state_d = S_WRITE;
                end else if (tmo_expire) begin
                    load_error_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q != S_WAIT_MEM);
        RegWrite   = (state_q == S_WRITE) && wr_en_q;
        WriteAddr  = addr_q;
        WriteData  = data_q;
        fwd_valid  = (state_q != S_IDLE) && wr_en_q;
        fwd_addr   = addr_q;
        load_error = load_error_q;
    end
endmodule

// File: tb/tb_mips_writeback_stage.sv
// Bench for mips_writeback_stage: directed scenarios, then randomized traffic against a write-queue reference model.
module tb_mips_writeback_stage;
`ifdef WB_LOAD_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 64;
`endif
    localparam int MAXD = (TB_TMO - 1 < 5) ? TB_TMO - 1 : 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic        in_mem_to_reg = 1'b0;
    logic [4:0]  in_write_addr = '0;
    logic [31:0] in_alu_result = '0;
    logic [1:0]  in_load_size = '0;
    logic        in_load_signed = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic        load_error;

    mips_writeback_stage #(
        .MIPS_REG_ADDR_W_m1 (4),
        .MIPS_REG_DATA_W_m1 (31),
        .TIMEOUT_CYCLES     (TB_TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_reg_write   (in_reg_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_write_addr  (in_write_addr),
        .in_alu_result  (in_alu_result),
        .in_load_size   (in_load_size),
        .in_load_signed (in_load_signed),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .RegWrite       (RegWrite),
        .WriteAddr      (WriteAddr),
        .WriteData      (WriteData),
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .load_error     (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Reference extraction written as plain arithmetic on the little-endian word.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] size, input logic sgn);
        longint v;
        longint w;
        w = {32'd0, rd};
        if (size == 2'd0) begin
            v = (w / (64'd1 << (8 * off))) % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = (w / ((off >= 2'd2) ? 65536 : 1)) % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic we, input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_reg_write = we; in_mem_to_reg = 1'b0;
        in_write_addr = a; in_alu_result = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drive_load(input logic we, input logic [4:0] a, input logic [31:0] alu,
                              input logic [1:0] size, input logic sgn);
        in_valid = 1'b1; in_reg_write = we; in_mem_to_reg = 1'b1;
        in_write_addr = a; in_alu_result = alu; in_load_size = size; in_load_signed = sgn;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"},  {31'd0, in_ready},   32'd1);
        chk({tag, "_we"},   {31'd0, RegWrite},   32'd0);
        chk({tag, "_wa"},   {27'd0, WriteAddr},  32'd0);
        chk({tag, "_wd"},   WriteData,           32'd0);
        chk({tag, "_fv"},   {31'd0, fwd_valid},  32'd0);
        chk({tag, "_fa"},   {27'd0, fwd_addr},   32'd0);
        chk({tag, "_lerr"}, {31'd0, load_error}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && RegWrite) begin
            if (exp_q.size() == 0) begin
                chk("spurious_wr", {27'd0, WriteAddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rnd_wr_addr", {27'd0, WriteAddr}, {27'd0, e.addr});
                chk("rnd_wr_data", WriteData, e.data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;

        drive_alu(1'b1, 5'd5, 32'h1234_5678);
        chk("alu_we",   {31'd0, RegWrite}, 32'd1);
        chk("alu_addr", {27'd0, WriteAddr}, 32'd5);
        chk("alu_data", WriteData, 32'h1234_5678);
        step();
        chk("alu_we_drop", {31'd0, RegWrite}, 32'd0);

        drive_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
        chk("r0_we",  {31'd0, RegWrite}, 32'd0);
        chk("r0_rdy", {31'd0, in_ready}, 32'd1);
        step();

        for (int s = 1; s >= 0; s--) begin
            drive_load(1'b1, 5'd7, 32'hA5A5_0002, 2'b00, s[0]);
            chk("lb_rdy_wait", {31'd0, in_ready}, 32'd0);
            chk("lb_fwd_v",    {31'd0, fwd_valid}, 32'd1);
            chk("lb_fwd_a",    {27'd0, fwd_addr}, 32'd7);
            step();
            step();
            chk("lb_rdy_wait2", {31'd0, in_ready}, 32'd0);
            chk("lb_no_we",     {31'd0, RegWrite}, 32'd0);
            mem_rvalid = 1'b1; mem_rdata = 32'h00F0_0000;
            step();
            mem_rvalid = 1'b0;
            chk("lb_we",   {31'd0, RegWrite}, 32'd1);
            chk("lb_addr", {27'd0, WriteAddr}, 32'd7);
            chk(s ? "lb_sext" : "lb_zext", WriteData, s ? 32'hFFFF_FFF0 : 32'h0000_00F0);
            step();
        end

        drive_load(1'b1, 5'd9, 32'h0000_0102, 2'b01, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
        step();
        mem_rvalid = 1'b0;
        chk("lh_data", WriteData, 32'hFFFF_8001);
        for (int i = 0; i < 3; i++) begin
            drive_alu(1'b1, 5'(10 + i), 32'h100 + 32'(i));
            chk("b2b_we",   {31'd0, RegWrite}, 32'd1);
            chk("b2b_addr", {27'd0, WriteAddr}, 32'(10 + i));
            chk("b2b_data", WriteData, 32'h100 + 32'(i));
        end
        step();
        chk("b2b_end", {31'd0, RegWrite}, 32'd0);

        drive_load(1'b1, 5'd12, 32'h0, 2'b10, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        check_reset_outputs("rst_mid_load");
        step();
        chk("rst_mid_load_we2", {31'd0, RegWrite}, 32'd0);

`ifdef WB_LOAD_TIMEOUT_EN
        drive_load(1'b1, 5'd3, 32'h0, 2'b10, 1'b0);
        repeat (TB_TMO - 1) step();
        chk("tmo_pre_err", {31'd0, load_error}, 32'd0);
        chk("tmo_pre_rdy", {31'd0, in_ready}, 32'd0);
        step();
        chk("tmo_err", {31'd0, load_error}, 32'd1);
        chk("tmo_rdy", {31'd0, in_ready}, 32'd1);
        chk("tmo_we",  {31'd0, RegWrite}, 32'd0);
        drive_alu(1'b1, 5'd4, 32'h44);
        chk("tmo_sticky", {31'd0, load_error}, 32'd1);
        chk("tmo_next_op", WriteData, 32'h44);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("tmo_clear");
`endif

        mon_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic        is_load, we, sgn;
            logic [4:0]  a;
            logic [31:0] alu, rd;
            logic [1:0]  size;
            int          gap, dly;
            is_load = 1'($urandom % 2);
            we      = ($urandom % 4) != 0;
            a       = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
            alu     = $urandom;
            size    = 2'($urandom);
            sgn     = 1'($urandom);
            gap     = $urandom % 3;
            for (int g = 0; g < gap; g++) begin
                mem_rvalid = 1'($urandom % 2);
                mem_rdata  = $urandom;
                step();
            end
            mem_rvalid = 1'b0;
            chk("rnd_rdy", {31'd0, in_ready}, 32'd1);
            if (!is_load) begin
                drive_alu(we, a, alu);
                if (we && a != 5'd0) exp_q.push_back('{a, alu});
            end else begin
                drive_load(we, a, alu, size, sgn);
                chk("rnd_ld_rdy", {31'd0, in_ready}, 32'd0);
                chk("rnd_fwd_v",  {31'd0, fwd_valid}, {31'd0, (we && a != 5'd0)});
                if (we && a != 5'd0) chk("rnd_fwd_a", {27'd0, fwd_addr}, {27'd0, a});
                dly = $urandom_range(0, MAXD);
                repeat (dly) step();
                rd = $urandom;
                mem_rvalid = 1'b1; mem_rdata = rd;
                if (we && a != 5'd0) exp_q.push_back('{a, ref_load(rd, alu[1:0], size, sgn)});
                step();
                mem_rvalid = 1'b0;
            end
        end
        repeat (3) step();
        mon_en = 1'b0;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        chk("rnd_lerr", {31'd0, load_error}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mips_writeback_stage.md
Name: mips_writeback_stage

Overview:
- Final pipeline stage of the MIPS32 datapath; sits directly upstream of the register file and drives its RegWrite/WriteAddr/WriteData write port.
- Accepts retired instructions from the MEM stage and selects the ALU result or load data as the write value.
- Aligns, sign-extends and zero-extends load data, then issues exactly one register write per retired instruction.
- Provides a forwarding tap for the EX-stage bypass logic.

Parameters:
MIPS_REG_ADDR_W_m1, 4, register address width minus 1
MIPS_REG_DATA_W_m1, 31, data width minus 1
TIMEOUT_CYCLES, 64, load-response wait limit (used only with the optional feature)

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept this cycle
in_reg_write  in  1  instruction writes a register
in_mem_to_reg  in  1  write value comes from memory (load)
in_write_addr  in  5  destination register
in_alu_result  in  32  ALU result; bits [1:0] are the load byte offset
in_load_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
in_load_signed  in  1  1 = sign-extend, 0 = zero-extend
mem_rvalid  in  1  load data valid
mem_rdata  in  32  raw aligned word from data memory
RegWrite  out  1  register-file write enable
WriteAddr  out  5  register-file write address
WriteData  out  32  register-file write data
fwd_valid  out  1  a write is in flight or pending (bypass hint)
fwd_addr  out  5  destination of in-flight write
load_error  out  1  sticky timeout flag (optional feature)

Behaviour:
- Reset: state IDLE; in_ready=1; RegWrite=0, WriteAddr=0, WriteData=0, fwd_valid=0, fwd_addr=0, load_error=0.
- Reset mid-load discards the pending load; no write is issued.
- Handshake: transfer occurs when in_valid & in_ready are both high on a posedge.
- in_ready = 1 in IDLE and WRITE; 0 in WAIT_MEM.
- State IDLE / WRITE on transfer:
  - in_mem_to_reg=0: register addr/ALU result; go to WRITE. Outputs are registered, so RegWrite is high in the cycle after the transfer (latency 1).
  - in_mem_to_reg=1: latch addr, size, signed flag and offset; go to WAIT_MEM.
  - No transfer: go to IDLE.
- WAIT_MEM: on mem_rvalid, extract the field and go to WRITE (RegWrite is high in the next cycle). A mem_rvalid outside WAIT_MEM is ignored.
- RegWrite is high for exactly one cycle per instruction, and only when in_reg_write=1 and addr≠0. Writes to $0 are suppressed, but the instruction still retires.
- Back-to-back: a transfer while in WRITE is legal and yields consecutive single-cycle writes.
- Load extraction (little-endian):
  - byte = rdata[8*off+7 : 8*off]
  - half = rdata[16*off[1]+15 : 16*off[1]]; off[0] is ignored
  - word = rdata
  - Extension is sign or zero per the latched flag, to 32 bits.
- fwd_valid=1 in WAIT_MEM and WRITE when the pending instruction writes a nonzero register; fwd_addr holds that destination.

Optional Feature:
- Macro WB_LOAD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_MEM and increments each cycle without mem_rvalid.
  - On reaching TIMEOUT_CYCLES: drop the load (no register write), set load_error (sticky until rst), return to IDLE.
  - mem_rvalid in the same cycle as expiry wins, and the load completes normally.
- Undefined: no counter; WAIT_MEM waits indefinitely; load_error is tied to 0.

Test Plan:
- After rst, transfer ALU op addr=5, alu=0x12345678 -> next cycle RegWrite=1, WriteAddr=5, WriteData=0x12345678; the following cycle RegWrite=0.
- Transfer ALU op to addr=0 with reg_write=1 -> RegWrite stays 0; in_ready stays 1.
- Load byte signed, offset 2, then mem_rvalid after 3 cycles with rdata=0x00F00000 -> in_ready=0 while waiting; WriteData=0xFFFFFFF0 one cycle after rvalid. Repeat unsigned -> 0x000000F0.
- Load half signed, offset 2, rdata=0x8001_0000 -> 0xFFFF8001; then three back-to-back ALU ops -> three consecutive single-cycle writes.
- Assert rst while in WAIT_MEM, then mem_rvalid -> no RegWrite; all outputs return to their reset values.
- With WB_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no rvalid -> no write, load_error=1 after 4 cycles, in_ready=1; load_error is held until rst.
